icache_refill_responder: RTL and testbench

//  Memory-side responder for the instruction-cache refill bus (io_mem_cmd / io_mem_rsp).

---
 rtl/icache_refill_responder_if.sv | 25 ++
 rtl/icache_refill_responder.sv | 134 +++++++++++++
 tb/tb_icache_refill_responder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_responder_if.sv
// Refill command/response channel and the req/ack backing bus seen by the I-cache refill responder.
interface icache_refill_responder_if;
  logic        cmdValid;
  logic        cmdReady;
  logic [31:0] cmdAddress;
  logic [2:0]  cmdSize;
  logic        rspValid;
  logic [31:0] rspData;
  logic        rspError;
  logic        busReq;
  logic [31:0] busAddr;
  logic        busAck;
  logic        busErr;
  logic [31:0] busRdata;

  modport slave (
    input  cmdValid, cmdAddress, cmdSize, busAck, busErr, busRdata,
    output cmdReady, rspValid, rspData, rspError, busReq, busAddr
  );

  modport master (
    output cmdValid, cmdAddress, cmdSize, busAck, busErr, busRdata,
    input  cmdReady, rspValid, rspData, rspError, busReq, busAddr
  );
endinterface

// File: rtl/icache_refill_responder.sv
// Memory-side responder for I-cache line refills: one command in, one backing-bus read per
// word, one single-cycle response beat per word; errors turn the rest of the line into error beats.
module icache_refill_responder #(
  parameter int MAX_SIZE = 5,
  parameter int TIMEOUT  = 255
) (
  input logic clk,
  input logic reset,
  icache_refill_responder_if.slave mem
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} stateT;

  localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);

  stateT       state, stateNext;
  logic [31:0] base, baseNext;
  logic [5:0]  beatIdx, beatIdxNext;
  logic [5:0]  beatTotal, beatTotalNext;
  logic [9:0]  waitCnt, waitCntNext;
  logic        rspValid, rspValidNext;
  logic        rspError, rspErrorNext;
  logic [31:0] rspData, rspDataNext;

  logic [2:0]  lowBits;
  logic [2:0]  sizeShift;
  logic [31:0] alignMask;
  logic [5:0]  cmdBeats;
  logic        sizeBad;
  logic        waitExpired;
  logic        beatEnd;
  logic        beatError;
  logic        lastBeat;
  logic        busReqInt;

  // Sub-word sizes still fetch one whole aligned word.
  assign lowBits     = (mem.cmdSize < 3'd2) ? 3'd2 : mem.cmdSize;
  assign sizeShift   = mem.cmdSize - 3'd2;
  assign alignMask   = ~((32'd1 << lowBits) - 32'd1);
  assign cmdBeats    = (mem.cmdSize < 3'd2) ? 6'd1 : (6'd1 << sizeShift);
  assign sizeBad     = (int'(mem.cmdSize) > MAX_SIZE);

  // A timeout only errors the beat if the bus did not answer in that same cycle.
  assign waitExpired = (waitCnt == TIMEOUT_CNT);
  assign beatEnd     = mem.busErr | mem.busAck | waitExpired;
  assign beatError   = mem.busErr | (waitExpired & ~mem.busAck);
  assign lastBeat    = ((beatIdx + 6'd1) == beatTotal);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      base      <= '0;
      beatIdx   <= '0;
      beatTotal <= '0;
      waitCnt   <= '0;
      rspValid  <= 1'b0;
      rspError  <= 1'b0;
      rspData   <= '0;
    end else begin
      state     <= stateNext;
      base      <= baseNext;
      beatIdx   <= beatIdxNext;
      beatTotal <= beatTotalNext;
      waitCnt   <= waitCntNext;
      rspValid  <= rspValidNext;
      rspError  <= rspErrorNext;
      rspData   <= rspDataNext;
    end
  end

  always_comb begin
    stateNext     = state;
    baseNext      = base;
    beatIdxNext   = beatIdx;
    beatTotalNext = beatTotal;
    waitCntNext   = waitCnt;
    rspValidNext  = 1'b0;
    rspErrorNext  = 1'b0;
    rspDataNext   = '0;

    case (state)
      IDLE: begin
        if (mem.cmdValid) begin
          baseNext    = mem.cmdAddress & alignMask;
          beatIdxNext = '0;
          waitCntNext = '0;
          if (sizeBad) begin
            beatTotalNext = 6'd1;
            stateNext     = DRAIN;
          end else begin
            beatTotalNext = cmdBeats;
            stateNext     = READ;
          end
        end
      end

      READ: begin
        if (beatEnd) begin
          rspValidNext = 1'b1;
          rspErrorNext = beatError;
          rspDataNext  = beatError ? 32'd0 : mem.busRdata;
          beatIdxNext  = beatIdx + 6'd1;
          waitCntNext  = '0;
          if (lastBeat) begin
            stateNext = IDLE;
          end else if (beatError) begin
            stateNext = DRAIN;
          end
        end else begin
          waitCntNext = waitCnt + 10'd1;
        end
      end

      DRAIN: begin
        rspValidNext = 1'b1;
        rspErrorNext = 1'b1;
        beatIdxNext  = beatIdx + 6'd1;
        if (lastBeat) begin
          stateNext = IDLE;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  // Ready is gated by reset so it reads 0 while reset is held, not just after.
  assign busReqInt    = (state == READ);
  assign mem.busReq   = busReqInt;
  assign mem.busAddr  = busReqInt ? (base + {24'd0, beatIdx, 2'b00}) : 32'd0;
  assign mem.cmdReady = (state == IDLE) & reset;
  assign mem.rspValid = rspValid;
  assign mem.rspError = rspError;
  assign mem.rspData  = rspData;
endmodule

// File: tb/tb_icache_refill_responder.sv
// Randomized scoreboard bench for icache_refill_responder: a memory responder, a command driver
// and a response monitor share expectation queues built from the line-refill rules.
module tb_icache_refill_responder;
  localparam int TIMEOUT  = 255;
  localparam int MAX_SIZE = 5;
  localparam int KIND_ACK = 0;
  localparam int KIND_ERR = 1;
  localparam int KIND_NEVER = 2;

  typedef struct {
    logic [31:0] data;
    logic        error;
    logic        last;
    int          timing;
  } rspT;

  typedef struct {
    logic [31:0] addr;
    int          lat;
    int          kind;
  } planT;

  logic clk;
  logic resetN;
  int   cyc;
  int   errCount;
  int   checkCount;

  rspT  expQ[$];
  planT planQ[$];
  int   ackCycQ[$];

  icache_refill_responder_if ifc();

  icache_refill_responder #(
    .MAX_SIZE(MAX_SIZE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(resetN),
    .mem  (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memFn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: actual=%h expected=%h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: what a line refill of this address/size must produce, given the bus plan.
  task automatic buildExpectation(input logic [31:0] addr, input logic [2:0] size, input int lat,
                                  input int errBeat, input int toBeat);
    int          beats;
    int          low;
    logic [31:0] base;
    bit          failed;
    rspT         e;
    planT        p;
    low   = (size < 2) ? 2 : int'(size);
    beats = (size < 2) ? 1 : (1 << (int'(size) - 2));
    base  = addr & ~((32'd1 << low) - 32'd1);
    if (int'(size) > MAX_SIZE) begin
      e.data = 32'd0; e.error = 1'b1; e.last = 1'b1; e.timing = 0;
      expQ.push_back(e);
      return;
    end
    failed = 1'b0;
    for (int i = 0; i < beats; i++) begin
      e.last   = (i == beats - 1);
      e.data   = 32'd0;
      e.error  = 1'b1;
      p.addr   = base + 32'(4 * i);
      p.lat    = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
      if (failed) begin
        e.timing = 2;
      end else if (i == toBeat) begin
        p.kind = KIND_NEVER; planQ.push_back(p);
        e.timing = 0; failed = 1'b1;
      end else if (i == errBeat) begin
        p.kind = KIND_ERR; planQ.push_back(p);
        e.timing = 1; failed = 1'b1;
      end else begin
        p.kind = KIND_ACK; planQ.push_back(p);
        e.data = memFn(p.addr); e.error = 1'b0; e.timing = 1;
      end
      expQ.push_back(e);
    end
  endtask

  // Backing-memory responder: follows the per-beat plan and polices bus_req/bus_addr.
  planT curPlan;
  bit   inBeat;
  int   waitCount;
  always @(negedge clk) begin
    ifc.busAck   = 1'b0;
    ifc.busErr   = 1'b0;
    ifc.busRdata = $urandom;
    if (!ifc.busReq) begin
      if (inBeat && curPlan.kind == KIND_NEVER)
        checkOutput("timeoutReqCycles", 32'(waitCount), 32'(TIMEOUT + 1));
      else if (inBeat)
        checkOutput("reqHeldUntilAck", {31'd0, ifc.busReq}, 32'd1);
      inBeat = 1'b0;
      ifc.busAck = 1'($urandom_range(0, 1));
      ifc.busErr = 1'($urandom_range(0, 1));
    end else begin
      if (!inBeat) begin
        if (planQ.size() == 0) begin
          checkOutput("unexpectedReq", {31'd0, ifc.busReq}, 32'd0);
        end else begin
          curPlan   = planQ.pop_front();
          inBeat    = 1'b1;
          waitCount = 0;
          checkOutput("busAddr", ifc.busAddr, curPlan.addr);
        end
      end
      if (inBeat) begin
        if (curPlan.kind != KIND_NEVER && waitCount == curPlan.lat) begin
          if (curPlan.kind == KIND_ERR) begin
            ifc.busErr = 1'b1;
            ifc.busAck = 1'($urandom_range(0, 1));
          end else begin
            ifc.busAck   = 1'b1;
            ifc.busRdata = memFn(curPlan.addr);
          end
          ackCycQ.push_back(cyc);
          inBeat = 1'b0;
        end
        waitCount++;
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a beat is presented.
  int  lastRspCyc;
  rspT got;
  always @(negedge clk) begin
    if (ifc.rspValid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedRsp", {31'd0, ifc.rspValid}, 32'd0);
      end else begin
        got = expQ.pop_front();
        checkOutput("rspData", ifc.rspData, got.data);
        checkOutput("rspError", {31'd0, ifc.rspError}, {31'd0, got.error});
        checkOutput("cmdReadyWithBeat", {31'd0, ifc.cmdReady}, {31'd0, got.last});
        if (got.timing == 1) begin
          if (ackCycQ.size() == 0)
            checkOutput("rspWithoutBusAnswer", {31'd0, ifc.rspValid}, 32'd0);
          else
            checkOutput("rspLatency", 32'(cyc), 32'(ackCycQ.pop_front() + 1));
        end else if (got.timing == 2) begin
          checkOutput("drainSpacing", 32'(cyc), 32'(lastRspCyc + 1));
        end
      end
      lastRspCyc = cyc;
    end else begin
      checkOutput("idleRspData", ifc.rspData, 32'd0);
      checkOutput("idleRspError", {31'd0, ifc.rspError}, 32'd0);
    end
  end

  task automatic issueCommand(input logic [31:0] addr, input logic [2:0] size, input int lat,
                              input int errBeat, input int toBeat);
    bit accepted;
    accepted = 1'b0;
    for (int i = 0; i < 100 && !accepted; i++) begin
      @(negedge clk);
      if (ifc.cmdReady) begin
        buildExpectation(addr, size, lat, errBeat, toBeat);
        ifc.cmdValid   = 1'b1;
        ifc.cmdAddress = addr;
        ifc.cmdSize    = size;
        accepted       = 1'b1;
      end
    end
    checkOutput("cmdAccepted", {31'd0, accepted}, 32'd1);
    @(negedge clk);
    checkOutput("readyDropsAfterAccept", {31'd0, ifc.cmdReady}, 32'd0);
    ifc.cmdValid   = 1'b0;
    ifc.cmdAddress = $urandom;
    ifc.cmdSize    = 3'($urandom_range(0, 7));
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] size, input int lat,
                               input int errBeat, input int toBeat);
    issueCommand(addr, size, lat, errBeat, toBeat);
    for (int i = 0; i < 2000 && expQ.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checkOutput("beatsOutstanding", 32'(expQ.size()), 32'd0);
    checkOutput("busPlansUnused", 32'(planQ.size()), 32'd0);
    expQ.delete();
    planQ.delete();
    ackCycQ.delete();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [2:0] rndSize;
  int          rndBeats;
  int          rndErr;
  bit          found;

  initial begin
    cyc = 0; errCount = 0; checkCount = 0; lastRspCyc = 0;
    inBeat = 1'b0; waitCount = 0;
    ifc.cmdValid = 1'b0; ifc.cmdAddress = '0; ifc.cmdSize = '0;
    resetN = 1'b1;
    #1 resetN = 1'b0;
    #2;
    checkOutput("resetCmdReady", {31'd0, ifc.cmdReady}, 32'd0);
    checkOutput("resetBusReq", {31'd0, ifc.busReq}, 32'd0);
    checkOutput("resetBusAddr", ifc.busAddr, 32'd0);
    checkOutput("resetRspValid", {31'd0, ifc.rspValid}, 32'd0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    checkOutput("readyAfterReset", {31'd0, ifc.cmdReady}, 32'd1);

    applyStimulus(32'h0000_1004, 3'd5, 0, -1, -1);
    applyStimulus(32'h0000_3006, 3'd2, 3, -1, -1);
    applyStimulus(32'h0000_4010, 3'd5, 1, 3, -1);
    applyStimulus(32'h0000_5000, 3'd5, 0, -1, 0);
    applyStimulus(32'h0000_6000, 3'd6, 0, -1, -1);
    applyStimulus(32'h0000_7003, 3'd0, 2, -1, -1);
    applyStimulus(32'h0000_7103, 3'd1, 0, 0, -1);
    applyStimulus(32'hFFFF_FFF4, 3'd3, -1, -1, -1);
    applyStimulus(32'h0000_8abc, 3'd4, -1, -1, 2);
    applyStimulus(32'h0000_9000, 3'd7, 0, -1, -1);

    // Reset lands while beat 4 of a zero-wait line is on the bus.
    issueCommand(32'h0000_2000, 3'd5, 0, -1, -1);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (ifc.busReq && ifc.busAddr == 32'h0000_2010) found = 1'b1;
    end
    checkOutput("reachedBeat4", {31'd0, found}, 32'd1);
    #2 resetN = 1'b0;
    #1;
    checkOutput("abortBusReq", {31'd0, ifc.busReq}, 32'd0);
    checkOutput("abortRspValid", {31'd0, ifc.rspValid}, 32'd0);
    checkOutput("abortCmdReady", {31'd0, ifc.cmdReady}, 32'd0);
    expQ.delete();
    planQ.delete();
    ackCycQ.delete();
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    checkOutput("readyAfterAbort", {31'd0, ifc.cmdReady}, 32'd1);
    applyStimulus(32'h0000_2468, 3'd5, -1, -1, -1);

    for (int n = 0; n < 40; n++) begin
      rndSize  = 3'($urandom_range(0, 7));
      rndBeats = (rndSize < 2) ? 1 : (1 << (int'(rndSize) - 2));
      rndErr   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rndBeats - 1)) : -1;
      applyStimulus($urandom, rndSize, -1, rndErr, -1);
    end

    repeat (5) @(negedge clk);
    checkOutput("leftoverRsp", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end
endmodule
